mdc_stage_param: RTL and testbench

- Parametrised radix-2 MDC FFT stage: two complex input lanes, input delay line, commutator, second delay line, butterfly and twiddle multiply on the lower lane.
- Generalises the fixed-depth, fixed-width stage blocks:
  - delay depth and widths set by parameters;
  - internal frame counter;
  - valid/sync handling with stall;
  - selectable scaling, rounding and saturation;
  - external twiddle ROM through an address port.
- Instances chain lane-to-lane to build the 32-point pipeline and larger sizes.

---
 rtl/mdc_stage_param_if.sv | 25 ++
 rtl/mdc_stage_param.sv | 137 +++++++++++++
 tb/tb_mdc_stage_param.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mdc_stage_param_if.sv
// Port bundle of one radix-2 MDC stage: input lane pair, twiddle ROM port and output lane pair.
interface mdc_stage_param_if #(
  parameter int WIDTH = 9,
  parameter int TW_W  = 9,
  parameter int AW    = 2
);
  logic                    in_valid;
  logic                    sync;
  logic                    mul_bypass;
  logic signed [WIDTH-1:0] in_up_re, in_up_im, in_low_re, in_low_im;
  logic        [AW-1:0]    tw_addr;
  logic signed [TW_W-1:0]  tw_re, tw_im;
  logic                    out_valid;
  logic signed [WIDTH-1:0] out_up_re, out_up_im, out_low_re, out_low_im;

  modport master (
    output in_valid, sync, mul_bypass, in_up_re, in_up_im, in_low_re, in_low_im, tw_re, tw_im,
    input  tw_addr, out_valid, out_up_re, out_up_im, out_low_re, out_low_im
  );

  modport slave (
    input  in_valid, sync, mul_bypass, in_up_re, in_up_im, in_low_re, in_low_im, tw_re, tw_im,
    output tw_addr, out_valid, out_up_re, out_up_im, out_low_re, out_low_im
  );
endinterface

// File: rtl/mdc_stage_param.sv
// Parametrised radix-2 MDC FFT stage: delay line, commutator, second delay line,
// butterfly and twiddle multiply on the lower lane, one register stage at the output.
module mdc_stage_param #(
  parameter int WIDTH = 9,
  parameter int DELAY = 4,
  parameter int TW_W  = 9,
  parameter int SCALE = 0
) (
  input logic              clk,
  input logic              rst,
  mdc_stage_param_if.slave bus
);
  localparam int LOG2D = $clog2(DELAY);
  localparam int CW    = LOG2D + 1;
  localparam int AW    = (LOG2D > 0) ? LOG2D : 1;
  localparam int W1    = WIDTH + 1;
  localparam int PW    = WIDTH + TW_W + 1;
  localparam int FR    = TW_W - 2;
  localparam logic signed [PW-1:0] MAXV = {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] MINV = {{(PW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic signed [PW-1:0] RND  = PW'(2 ** (FR - 1));

  function automatic logic signed [WIDTH-1:0] sat_w(input logic signed [PW-1:0] x);
    if (x > MAXV)      return MAXV[WIDTH-1:0];
    else if (x < MINV) return MINV[WIDTH-1:0];
    else               return x[WIDTH-1:0];
  endfunction

  function automatic logic signed [WIDTH-1:0] bfly_out(input logic signed [W1-1:0] x);
    logic signed [PW-1:0] t;
    t = PW'(x);
    if (SCALE != 0) t = (t + PW'(1)) >>> 1;
    return sat_w(t);
  endfunction

  function automatic logic signed [WIDTH-1:0] rnd_mul(input logic signed [PW-1:0] x);
    return sat_w((x + RND) >>> FR);
  endfunction

  logic          acc, sy, p, fill, fill_cond;
  logic [CW-1:0] cnt, e;

  logic signed [WIDTH-1:0] d1_re [DELAY];
  logic signed [WIDTH-1:0] d1_im [DELAY];
  logic signed [WIDTH-1:0] d2_re [DELAY];
  logic signed [WIDTH-1:0] d2_im [DELAY];

  logic signed [WIDTH-1:0] cu_re, cu_im, cl_re, cl_im;
  logic signed [W1-1:0]    s_re, s_im, d_re, d_im;
  logic signed [WIDTH-1:0] bs_re, bs_im, bd_re, bd_im, lo_re, lo_im;
  logic signed [PW-1:0]    m_re, m_im;

  logic                    vld_p1;
  logic signed [WIDTH-1:0] up_re_p1, up_im_p1, low_re_p1, low_im_p1;

  // sync restarts the frame at index 0 on the very sample that carries it
  assign acc       = bus.in_valid;
  assign sy        = bus.in_valid & bus.sync;
  assign e         = sy ? '0 : cnt;
  assign p         = e[LOG2D];
  assign fill_cond = ~sy & (fill | p);

  generate
    if (LOG2D > 0) begin : g_addr
      assign bus.tw_addr = e[AW-1:0];
    end else begin : g_addr0
      assign bus.tw_addr = '0;
    end
  endgenerate

  assign cu_re = p ? d1_re[DELAY-1] : bus.in_up_re;
  assign cu_im = p ? d1_im[DELAY-1] : bus.in_up_im;
  assign cl_re = p ? bus.in_up_re   : d1_re[DELAY-1];
  assign cl_im = p ? bus.in_up_im   : d1_im[DELAY-1];

  assign s_re = W1'(d2_re[DELAY-1]) + W1'(cl_re);
  assign s_im = W1'(d2_im[DELAY-1]) + W1'(cl_im);
  assign d_re = W1'(d2_re[DELAY-1]) - W1'(cl_re);
  assign d_im = W1'(d2_im[DELAY-1]) - W1'(cl_im);

  assign bs_re = bfly_out(s_re);
  assign bs_im = bfly_out(s_im);
  assign bd_re = bfly_out(d_re);
  assign bd_im = bfly_out(d_im);

  assign m_re  = PW'(bd_re) * PW'(bus.tw_re) - PW'(bd_im) * PW'(bus.tw_im);
  assign m_im  = PW'(bd_re) * PW'(bus.tw_im) + PW'(bd_im) * PW'(bus.tw_re);
  assign lo_re = bus.mul_bypass ? bd_re : rnd_mul(m_re);
  assign lo_im = bus.mul_bypass ? bd_im : rnd_mul(m_im);

  // p0 -> p1: output registers only load on a valid pair so they hold otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      fill      <= 1'b0;
      vld_p1    <= 1'b0;
      up_re_p1  <= '0;
      up_im_p1  <= '0;
      low_re_p1 <= '0;
      low_im_p1 <= '0;
      for (int i = 0; i < DELAY; i++) begin
        d1_re[i] <= '0;
        d1_im[i] <= '0;
        d2_re[i] <= '0;
        d2_im[i] <= '0;
      end
    end else begin
      vld_p1 <= acc & fill_cond;
      if (acc) begin
        cnt      <= e + CW'(1);
        fill     <= fill_cond;
        d1_re[0] <= bus.in_low_re;
        d1_im[0] <= bus.in_low_im;
        d2_re[0] <= cu_re;
        d2_im[0] <= cu_im;
        for (int i = 1; i < DELAY; i++) begin
          d1_re[i] <= d1_re[i-1];
          d1_im[i] <= d1_im[i-1];
          d2_re[i] <= d2_re[i-1];
          d2_im[i] <= d2_im[i-1];
        end
        if (fill_cond) begin
          up_re_p1  <= bs_re;
          up_im_p1  <= bs_im;
          low_re_p1 <= lo_re;
          low_im_p1 <= lo_im;
        end
      end
    end
  end

  assign bus.out_valid  = vld_p1;
  assign bus.out_up_re  = up_re_p1;
  assign bus.out_up_im  = up_im_p1;
  assign bus.out_low_re = low_re_p1;
  assign bus.out_low_im = low_im_p1;
endmodule

// File: tb/tb_mdc_stage_param.sv
// Bench for mdc_stage_param: two instances (SCALE=0 and SCALE=1) fed identical stimulus,
// compared against a frame-history reference model, directed tables and corner sequences.
module tb_mdc_stage_param;
  localparam int W  = 9;
  localparam int D  = 4;
  localparam int TW = 9;
  localparam int AW = 2;
  localparam int MAXI = (1 << (W - 1)) - 1;
  localparam int MINI = -(1 << (W - 1));

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mdc_stage_param_if #(.WIDTH(W), .TW_W(TW), .AW(AW)) bus0 ();
  mdc_stage_param_if #(.WIDTH(W), .TW_W(TW), .AW(AW)) bus1 ();

  mdc_stage_param #(.WIDTH(W), .DELAY(D), .TW_W(TW), .SCALE(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  mdc_stage_param #(.WIDTH(W), .DELAY(D), .TW_W(TW), .SCALE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int   rom_re [D] = '{128, 91, 0, -91};
  int   rom_im [D] = '{0, -91, -128, -91};
  logic force_tw;
  int   f_re, f_im;

  always_comb begin
    bus0.tw_re = force_tw ? TW'(f_re) : TW'(rom_re[bus0.tw_addr]);
    bus0.tw_im = force_tw ? TW'(f_im) : TW'(rom_im[bus0.tw_addr]);
    bus1.tw_re = force_tw ? TW'(f_re) : TW'(rom_re[bus1.tw_addr]);
    bus1.tw_im = force_tw ? TW'(f_im) : TW'(rom_im[bus1.tw_addr]);
  end

  int ncmp = 0;
  int nfail = 0;
  int hq_ur[$], hq_ui[$], hq_lr[$], hq_li[$];
  int exp_o [2][4];
  logic exp_v;
  int last_tw;

  typedef struct {
    int ar, ai, br, bi, tr, ti;
    logic byp;
    int u0r, u0i, l0r, l0i, u1r, u1i, l1r, l1i;
  } vec_t;
  vec_t tbl [8];

  function automatic int sat(int x);
    if (x > MAXI) return MAXI;
    if (x < MINI) return MINI;
    return x;
  endfunction

  function automatic int bsc(int x, int sc);
    return (sc != 0) ? sat((x + 1) >>> 1) : sat(x);
  endfunction

  function automatic int rmul(int x);
    return sat((x + (1 << (TW - 3))) >>> (TW - 2));
  endfunction

  task automatic chk(input string nm, input int act, input int expv);
    ncmp++;
    if (act != expv) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, "/vld0"}, int'(bus0.out_valid), int'(exp_v));
    chk({tag, "/ur0"}, int'(bus0.out_up_re), exp_o[0][0]);
    chk({tag, "/ui0"}, int'(bus0.out_up_im), exp_o[0][1]);
    chk({tag, "/lr0"}, int'(bus0.out_low_re), exp_o[0][2]);
    chk({tag, "/li0"}, int'(bus0.out_low_im), exp_o[0][3]);
    chk({tag, "/vld1"}, int'(bus1.out_valid), int'(exp_v));
    chk({tag, "/ur1"}, int'(bus1.out_up_re), exp_o[1][0]);
    chk({tag, "/ui1"}, int'(bus1.out_up_im), exp_o[1][1]);
    chk({tag, "/lr1"}, int'(bus1.out_low_re), exp_o[1][2]);
    chk({tag, "/li1"}, int'(bus1.out_low_im), exp_o[1][3]);
  endtask

  task automatic set_in(input logic v, input logic s, input logic byp,
                        input int ur, input int ui, input int lr, input int li);
    bus0.in_valid = v;  bus1.in_valid = v;
    bus0.sync = s;      bus1.sync = s;
    bus0.mul_bypass = byp; bus1.mul_bypass = byp;
    bus0.in_up_re = W'(ur);  bus1.in_up_re = W'(ur);
    bus0.in_up_im = W'(ui);  bus1.in_up_im = W'(ui);
    bus0.in_low_re = W'(lr); bus1.in_low_re = W'(lr);
    bus0.in_low_im = W'(li); bus1.in_low_im = W'(li);
  endtask

  task automatic model_clear();
    hq_ur.delete(); hq_ui.delete(); hq_lr.delete(); hq_li.delete();
  endtask

  // One clock: drive inputs, check twiddle address, advance the model, check outputs.
  task automatic step(input logic v, input logic s, input logic byp,
                      input int ur, input int ui, input int lr, input int li);
    int n, k, ar, ai, br, bi, tr, ti, dr, di;
    set_in(v, s, byp, ur, ui, lr, li);
    #1;
    if (v && s) model_clear();
    n = hq_ur.size();
    k = n % D;
    last_tw = int'(bus0.tw_addr);
    chk("tw_addr0", int'(bus0.tw_addr), k);
    chk("tw_addr1", int'(bus1.tw_addr), k);
    exp_v = 1'b0;
    if (v) begin
      if (n >= D) begin
        exp_v = 1'b1;
        if ((n % (2 * D)) >= D) begin
          ar = hq_ur[n-D]; ai = hq_ui[n-D]; br = ur; bi = ui;
        end else begin
          ar = hq_lr[n-2*D]; ai = hq_li[n-2*D]; br = hq_lr[n-D]; bi = hq_li[n-D];
        end
        tr = force_tw ? f_re : rom_re[k];
        ti = force_tw ? f_im : rom_im[k];
        for (int sc = 0; sc < 2; sc++) begin
          exp_o[sc][0] = bsc(ar + br, sc);
          exp_o[sc][1] = bsc(ai + bi, sc);
          dr = bsc(ar - br, sc);
          di = bsc(ai - bi, sc);
          if (byp) begin
            exp_o[sc][2] = dr;
            exp_o[sc][3] = di;
          end else begin
            exp_o[sc][2] = rmul(dr * tr - di * ti);
            exp_o[sc][3] = rmul(dr * ti + di * tr);
          end
        end
      end
      hq_ur.push_back(ur); hq_ui.push_back(ui);
      hq_lr.push_back(lr); hq_li.push_back(li);
    end
    @(posedge clk);
    #1;
    compare_all(v ? "acc" : "stall");
  endtask

  task automatic do_reset(input int cyc);
    set_in(1'b0, 1'b0, 1'b1, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    model_clear();
    exp_v = 1'b0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 4; j++) exp_o[i][j] = 0;
    compare_all("rst_async");
    chk("rst_tw_addr", int'(bus0.tw_addr), 0);
    repeat (cyc) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int st0, st1, st2;
    force_tw = 1'b0; f_re = 0; f_im = 0;
    tbl[0] = '{255, 0, 255, 0, 0, 0, 1'b1,     255, 0, 0, 0,       255, 0, 0, 0};
    tbl[1] = '{-256, 0, -256, 0, 0, 0, 1'b1,   -256, 0, 0, 0,      -256, 0, 0, 0};
    tbl[2] = '{255, 0, -256, 0, 0, 0, 1'b1,    -1, 0, 255, 0,      0, 0, 255, 0};
    tbl[3] = '{100, 0, 0, 0, 0, -128, 1'b0,    100, 0, 0, -100,    50, 0, 0, -50};
    tbl[4] = '{100, 0, 0, 0, 90, -90, 1'b0,    100, 0, 70, -70,    50, 0, 35, -35};
    tbl[5] = '{10, -20, 30, 40, 0, 0, 1'b1,    40, 20, -20, -60,   20, 10, -10, -30};
    tbl[6] = '{-7, 3, 2, -5, 128, 0, 1'b0,     -5, -2, -9, 8,      -2, -1, -4, 4};
    tbl[7] = '{200, -200, 200, -200, 0, 0, 1'b1, 255, -256, 0, 0,  200, -200, 0, 0};

    // Reset held for 3 cycles, then idle
    do_reset(3);
    repeat (10) step(1'b0, 1'b0, 1'b1, 0, 0, 0, 0);

    // Constant stream with three stalls
    st0 = $urandom_range(6, 10);
    st1 = $urandom_range(11, 15);
    st2 = $urandom_range(16, 20);
    for (int j = 0; j < 24; j++) begin
      if (j == st0 || j == st1 || j == st2) begin
        step(1'b0, 1'b0, 1'b1, 10, 0, 20, 0);
        chk("cs_stall_vld", int'(bus0.out_valid), 0);
      end
      step(1'b1, j == 0, 1'b1, 10, 0, 20, 0);
      chk("cs_vld", int'(bus0.out_valid), (j >= D) ? 1 : 0);
      if (j >= D) begin
        chk("cs_up", int'(bus0.out_up_re), ((((j - D) / D) % 2) == 0) ? 20 : 40);
        chk("cs_low", int'(bus0.out_low_re), 0);
      end
    end

    // Directed butterfly / saturation / twiddle table, four vectors per frame
    for (int f = 0; f < 2; f++) begin
      for (int j = 0; j < D; j++)
        step(1'b1, j == 0, 1'b1, tbl[f*D+j].ar, tbl[f*D+j].ai, 0, 0);
      for (int j = 0; j < D; j++) begin
        force_tw = 1'b1;
        f_re = tbl[f*D+j].tr;
        f_im = tbl[f*D+j].ti;
        step(1'b1, 1'b0, tbl[f*D+j].byp, tbl[f*D+j].br, tbl[f*D+j].bi, 0, 0);
        chk("tbl_u0r", int'(bus0.out_up_re), tbl[f*D+j].u0r);
        chk("tbl_u0i", int'(bus0.out_up_im), tbl[f*D+j].u0i);
        chk("tbl_l0r", int'(bus0.out_low_re), tbl[f*D+j].l0r);
        chk("tbl_l0i", int'(bus0.out_low_im), tbl[f*D+j].l0i);
        chk("tbl_u1r", int'(bus1.out_up_re), tbl[f*D+j].u1r);
        chk("tbl_u1i", int'(bus1.out_up_im), tbl[f*D+j].u1i);
        chk("tbl_l1r", int'(bus1.out_low_re), tbl[f*D+j].l1r);
        chk("tbl_l1i", int'(bus1.out_low_im), tbl[f*D+j].l1i);
      end
      force_tw = 1'b0;
    end

    // Resync at cnt=6
    for (int j = 0; j < 6; j++)
      step(1'b1, j == 0, 1'b0, j * 11 - 30, 7 - j, 50 - j * 9, j * 3);
    for (int j = 0; j < D; j++) begin
      step(1'b1, j == 0, 1'b0, j * 13 - 20, 5, -j * 17, 9);
      chk("resync_vld_low", int'(bus0.out_valid), 0);
    end
    for (int j = 0; j < D; j++) begin
      step(1'b1, 1'b0, 1'b0, 40 - j * 7, -j, 3 * j, -60);
      chk("resync_vld", int'(bus0.out_valid), 1);
      chk("resync_tw", last_tw, j);
    end

    // Mid-run reset, then refill
    do_reset(1);
    for (int j = 0; j < 2 * D; j++) begin
      step(1'b1, 1'b0, 1'b1, 17 * j - 60, 33 - j, -5 * j, j);
      chk("refill_vld", int'(bus0.out_valid), (j >= D) ? 1 : 0);
    end

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        do_reset(2);
      end else begin
        step($urandom_range(0, 9) < 8, $urandom_range(0, 59) == 0, 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 511)) - 256,
             int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 511)) - 256);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
